hyper_req_bridge: RTL and testbench

//  Upstream front end of hyper_xface. Accepts valid/ready memory requests (byte address, size, burst

---
 rtl/hyper_pkg.sv | 23 ++
 rtl/hyper_be_gen.sv | 34 +++
 rtl/hyper_req_bridge.sv | 220 ++++++++++++++++++++++
 tb/tb_hyper_req_bridge.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hyper_pkg.sv
// Shared types and defaults for the hyper_xface request bridge.
package hyper_pkg;

  typedef enum logic [1:0] {
    SZ_1B  = 2'd0,
    SZ_2B  = 2'd1,
    SZ_4B  = 2'd2,
    SZ_ILL = 2'd3
  } req_size_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_RD_COLLECT = 3'd3,
    ST_WR_DONE    = 3'd4
  } bridge_state_e;

  localparam logic [7:0]  LAT1X_DEF       = 8'd11;
  localparam logic [7:0]  LAT2X_DEF       = 8'd21;
  localparam int unsigned MAX_BURST_LIMIT = 63;

endpackage

// File: rtl/hyper_be_gen.sv
// Combinational byte-enable / write-data lane steering for sub-dword writes.
module hyper_be_gen
  import hyper_pkg::*;
(
  input  req_size_e   size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  always_comb begin
    byte_en_o  = '0;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    unique case (size_i)
      SZ_1B: byte_en_o = 4'b0001 << addr_lo_i;
      SZ_2B: begin
        byte_en_o  = 4'b0011 << addr_lo_i;
        misalign_o = addr_lo_i[0];
      end
      SZ_4B: begin
        byte_en_o  = 4'b1111;
        misalign_o = |addr_lo_i;
      end
      default: illegal_o = 1'b1;
    endcase
  end

  assign wdata_o = wdata_i << {addr_lo_i, 3'b000};

endmodule

// File: rtl/hyper_req_bridge.sv
// Valid/ready request front end for hyper_xface: validates, issues one access,
// and returns a response stream (read beats, write ack, or error).
module hyper_req_bridge
  import hyper_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned LAT1X     = 11,
  parameter int unsigned LAT2X     = 21,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic        req_reg_i,
  input  logic [1:0]  req_size_i,
  input  logic [5:0]  req_len_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_last_o,
  output logic        rsp_err_o,
  output logic        rd_req_o,
  output logic        wr_req_o,
  output logic        mem_or_reg_o,
  output logic [3:0]  wr_byte_en_o,
  output logic [5:0]  rd_num_dwords_o,
  output logic [31:0] addr_o,
  output logic [31:0] wr_d_o,
  input  logic [31:0] rd_d_i,
  input  logic        rd_rdy_i,
  input  logic        busy_i,
  input  logic        burst_wr_rdy_i,
  output logic [7:0]  latency_1x_o,
  output logic [7:0]  latency_2x_o
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  bridge_state_e state_q, state_d;
  logic          we_q, we_d;
  logic [5:0]    len_q, len_d;
  logic [5:0]    beat_q, beat_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;
  logic [3:0]    be_q, be_d;
  logic [5:0]    num_q, num_d;
  logic          reg_q, reg_d;
  logic          rd_req_q, rd_req_d;
  logic          wr_req_q, wr_req_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          rsp_last_q, rsp_last_d;
  logic          rsp_err_q, rsp_err_d;

  logic [3:0]    gen_be;
  logic [31:0]   gen_wd;
  logic          gen_misalign;
  logic          gen_illegal;
  logic          accept;
  logic          req_err;
  logic          beat_hit;
  logic          unused_burst_wr_rdy;

  assign unused_burst_wr_rdy = burst_wr_rdy_i;

  hyper_be_gen u_be_gen (
    .size_i     (req_size_e'(req_size_i)),
    .addr_lo_i  (req_addr_i[1:0]),
    .wdata_i    (req_wdata_i),
    .byte_en_o  (gen_be),
    .wdata_o    (gen_wd),
    .misalign_o (gen_misalign),
    .illegal_o  (gen_illegal)
  );

  assign req_ready_o = (state_q == ST_IDLE) && !busy_i && !reset;
  assign accept      = req_valid_i && req_ready_o;

  // Reads always move whole dwords, so size is ignored and only dword alignment matters.
  assign req_err = req_we_i ? (gen_illegal || gen_misalign)
                            : ((|req_addr_i[1:0]) || (req_len_i == 6'd0) ||
                               (32'(req_len_i) > MAX_BURST));

  assign beat_hit = !we_q && rd_rdy_i &&
                    ((state_q == ST_WAIT_START) || (state_q == ST_RD_COLLECT));

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    len_d       = len_q;
    beat_d      = beat_q;
    addr_d      = addr_q;
    wd_d        = wd_q;
    be_d        = be_q;
    num_d       = num_q;
    reg_d       = reg_q;
    rd_req_d    = 1'b0;
    wr_req_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    rsp_last_d  = 1'b0;
    rsp_err_d   = 1'b0;
    to_cnt_d    = (state_q == ST_IDLE) ? '0 : to_cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_last_d  = 1'b1;
          end else begin
            we_d     = req_we_i;
            len_d    = req_len_i;
            beat_d   = '0;
            addr_d   = req_addr_i;
            reg_d    = req_reg_i;
            wd_d     = req_we_i ? gen_wd : '0;
            be_d     = req_we_i ? gen_be : '0;
            num_d    = req_we_i ? 6'd1 : req_len_i;
            rd_req_d = !req_we_i;
            wr_req_d = req_we_i;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE:      state_d = ST_WAIT_START;
      ST_WAIT_START: if (busy_i) state_d = we_q ? ST_WR_DONE : ST_RD_COLLECT;
      ST_RD_COLLECT: ;
      ST_WR_DONE: begin
        if (!busy_i) begin
          rsp_valid_d = 1'b1;
          rsp_last_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A first rd_rdy can arrive before busy is seen, so beats are taken in WAIT_START too.
    if (beat_hit) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rd_d_i;
      beat_d      = beat_q + 6'd1;
      if (beat_q + 6'd1 == len_q) begin
        rsp_last_d = 1'b1;
        state_d    = ST_IDLE;
      end else begin
        state_d    = ST_RD_COLLECT;
      end
    end

    // Completion in the same cycle takes priority over timeout.
    if (state_q != ST_IDLE && state_d != ST_IDLE && to_cnt_q == TO_LAST) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = '0;
      rsp_err_d   = 1'b1;
      rsp_last_d  = 1'b1;
      state_d     = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      len_q       <= '0;
      beat_q      <= '0;
      to_cnt_q    <= '0;
      addr_q      <= '0;
      wd_q        <= '0;
      be_q        <= '0;
      num_q       <= '0;
      reg_q       <= 1'b0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      to_cnt_q    <= to_cnt_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
      be_q        <= be_d;
      num_q       <= num_d;
      reg_q       <= reg_d;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_data_o      = rsp_data_q;
  assign rsp_last_o      = rsp_last_q;
  assign rsp_err_o       = rsp_err_q;
  assign rd_req_o        = rd_req_q;
  assign wr_req_o        = wr_req_q;
  assign mem_or_reg_o    = reg_q;
  assign wr_byte_en_o    = be_q;
  assign rd_num_dwords_o = num_q;
  assign addr_o          = addr_q;
  assign wr_d_o          = wd_q;
  assign latency_1x_o    = 8'(LAT1X);
  assign latency_2x_o    = 8'(LAT2X);

endmodule

// File: tb/tb_hyper_req_bridge.sv
// Directed bench for hyper_req_bridge with a small hyper_xface/memory stub.
module tb_hyper_req_bridge;

  localparam int unsigned TMO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic        req_reg_i = 1'b0;
  logic [1:0]  req_size_i = '0;
  logic [5:0]  req_len_i = '0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        rsp_last_o;
  logic        rsp_err_o;
  logic        rd_req_o;
  logic        wr_req_o;
  logic        mem_or_reg_o;
  logic [3:0]  wr_byte_en_o;
  logic [5:0]  rd_num_dwords_o;
  logic [31:0] addr_o;
  logic [31:0] wr_d_o;
  logic [31:0] rd_d_i = '0;
  logic        rd_rdy_i = 1'b0;
  logic        busy_i = 1'b0;
  logic        burst_wr_rdy_i = 1'b0;
  logic [7:0]  latency_1x_o;
  logic [7:0]  latency_2x_o;

  always #5 clk = ~clk;

  hyper_req_bridge #(.MAX_BURST(8), .LAT1X(11), .LAT2X(21), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_reg_i(req_reg_i), .req_size_i(req_size_i), .req_len_i(req_len_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_last_o(rsp_last_o),
    .rsp_err_o(rsp_err_o), .rd_req_o(rd_req_o), .wr_req_o(wr_req_o),
    .mem_or_reg_o(mem_or_reg_o), .wr_byte_en_o(wr_byte_en_o),
    .rd_num_dwords_o(rd_num_dwords_o), .addr_o(addr_o), .wr_d_o(wr_d_o),
    .rd_d_i(rd_d_i), .rd_rdy_i(rd_rdy_i), .busy_i(busy_i),
    .burst_wr_rdy_i(burst_wr_rdy_i),
    .latency_1x_o(latency_1x_o), .latency_2x_o(latency_2x_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stub state and response monitor.
  logic        hold_busy = 1'b0;
  logic        mute = 1'b0;
  int          st = 0, k = 0, beat = 0, s_len = 0;
  logic [7:0]  s_idx;
  logic [3:0]  s_be;
  logic [31:0] s_wd;
  logic [31:0] mem [0:255];
  logic [31:0] q_data [$];
  logic        q_last [$];
  logic        q_err  [$];
  int          n_rd = 0, n_wr = 0;
  logic [3:0]  cap_be = '0;
  logic [31:0] cap_wd = '0;

  initial for (int i = 0; i < 256; i++) mem[i] = '0;

  always @(negedge clk) begin
    if (rsp_valid_o) begin
      q_data.push_back(rsp_data_o);
      q_last.push_back(rsp_last_o);
      q_err.push_back(rsp_err_o);
    end
    if (rd_req_o) n_rd++;
    if (wr_req_o) begin
      n_wr++;
      cap_be = wr_byte_en_o;
      cap_wd = wr_d_o;
    end
    rd_rdy_i = 1'b0;
    if (reset) begin
      st = 0;
      busy_i = hold_busy;
    end else begin
      case (st)
        0: begin
          busy_i = hold_busy;
          if (!mute && wr_req_o) begin
            s_idx = addr_o[9:2]; s_be = wr_byte_en_o; s_wd = wr_d_o;
            st = 1; k = 0; busy_i = 1'b1;
          end else if (!mute && rd_req_o) begin
            s_idx = addr_o[9:2]; s_len = int'(rd_num_dwords_o);
            st = 2; k = 0; beat = 0; busy_i = 1'b1;
          end
        end
        1: begin
          k++;
          if (k == 3) begin
            for (int b = 0; b < 4; b++)
              if (s_be[b]) mem[s_idx][8*b +: 8] = s_wd[8*b +: 8];
            busy_i = 1'b0; st = 0;
          end
        end
        default: begin
          k++;
          if (k >= 2) begin
            rd_rdy_i = 1'b1;
            rd_d_i = mem[s_idx + 8'(beat)];
            beat++;
            if (beat == s_len) begin busy_i = 1'b0; st = 0; end
          end
        end
      endcase
    end
  end

  task automatic clr();
    q_data.delete(); q_last.delete(); q_err.delete();
  endtask

  task automatic send(input logic we, input logic [1:0] size, input logic [5:0] len,
                      input logic [31:0] addr, input logic [31:0] wd);
    int n = 0;
    @(negedge clk); #2;
    while (!req_ready_o && n < 200) begin @(negedge clk); #2; n++; end
    check("ready_wait", {31'b0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_len_i = len;
    req_addr_i = addr; req_wdata_i = wd;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int c = 0;
    while (q_data.size() < n && c < 300) begin @(negedge clk); #1; c++; end
    repeat (3) @(negedge clk);
    #1 check("rsp_count", q_data.size(), n);
  endtask

  int nrw, cyc;
  logic [3:0] lasts;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_rsp_valid", {31'b0, rsp_valid_o}, 0);
    check("rst_rd_req", {31'b0, rd_req_o}, 0);
    check("rst_wr_req", {31'b0, wr_req_o}, 0);
    check("rst_ready", {31'b0, req_ready_o}, 0);
    check("rst_addr", addr_o, 0);
    check("rst_be", {28'b0, wr_byte_en_o}, 0);
    check("rst_lat1x", {24'b0, latency_1x_o}, 11);
    check("rst_lat2x", {24'b0, latency_2x_o}, 21);
    @(negedge clk) reset = 1'b0;

    clr(); send(1'b1, 2'd2, 6'd0, 32'h40, 32'hDEADBEEF); wait_rsp(1);
    check("w4_be", {28'b0, cap_be}, 32'hF);
    check("w4_wd", cap_wd, 32'hDEADBEEF);
    if (q_data.size() > 0) begin
      check("w4_data", q_data[0], 0);
      check("w4_last", {31'b0, q_last[0]}, 1);
      check("w4_err", {31'b0, q_err[0]}, 0);
    end

    clr(); send(1'b0, 2'd2, 6'd1, 32'h40, 32'h0); wait_rsp(1);
    if (q_data.size() > 0) begin
      check("r1_data", q_data[0], 32'hDEADBEEF);
      check("r1_last", {31'b0, q_last[0]}, 1);
      check("r1_err", {31'b0, q_err[0]}, 0);
    end

    clr(); send(1'b1, 2'd0, 6'd0, 32'h43, 32'hAA); wait_rsp(1);
    check("w1_be", {28'b0, cap_be}, 32'h8);
    check("w1_wd", cap_wd, 32'hAA000000);
    clr(); send(1'b0, 2'd2, 6'd1, 32'h40, 32'h0); wait_rsp(1);
    if (q_data.size() > 0) check("r1b_data", q_data[0], 32'hAAADBEEF);

    nrw = n_rd + n_wr;
    clr(); send(1'b1, 2'd1, 6'd0, 32'h41, 32'h1234);
    check("mis_valid", {31'b0, rsp_valid_o}, 1);
    check("mis_err", {31'b0, rsp_err_o}, 1);
    check("mis_last", {31'b0, rsp_last_o}, 1);
    repeat (5) @(negedge clk);
    #1 check("mis_no_pulse", n_rd + n_wr, nrw);

    for (int i = 0; i < 4; i++) begin
      clr(); send(1'b1, 2'd2, 6'd0, 32'h100 + 32'(4*i), 32'h11110000 + 32'(i)); wait_rsp(1);
    end
    clr(); send(1'b0, 2'd2, 6'd4, 32'h100, 32'h0); wait_rsp(4);
    lasts = '0;
    for (int i = 0; i < 4; i++) if (i < q_data.size()) begin
      check($sformatf("r4_data%0d", i), q_data[i], 32'h11110000 + 32'(i));
      check($sformatf("r4_err%0d", i), {31'b0, q_err[i]}, 0);
      lasts[i] = q_last[i];
    end
    check("r4_lasts", {28'b0, lasts}, 32'h8);

    nrw = n_rd + n_wr;
    clr(); send(1'b0, 2'd2, 6'd9, 32'h100, 32'h0);
    check("len9_err", {31'b0, rsp_err_o}, 1);
    clr(); send(1'b0, 2'd2, 6'd0, 32'h100, 32'h0);
    check("len0_err", {31'b0, rsp_err_o}, 1);
    clr(); send(1'b1, 2'd3, 6'd0, 32'h100, 32'h0);
    check("sz3_err", {31'b0, rsp_err_o}, 1);
    repeat (5) @(negedge clk);
    #1 check("err_no_pulse", n_rd + n_wr, nrw);

    @(negedge clk) hold_busy = 1'b1;
    repeat (2) @(negedge clk);
    #2 check("busy_ready", {31'b0, req_ready_o}, 0);
    hold_busy = 1'b0;
    repeat (2) @(negedge clk);

    mute = 1'b1;
    clr(); send(1'b0, 2'd2, 6'd1, 32'h40, 32'h0);
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!rsp_valid_o && cyc < int'(TMO) + 20);
    check("tmo_cycles", cyc, TMO);
    check("tmo_err", {31'b0, rsp_err_o}, 1);
    check("tmo_last", {31'b0, rsp_last_o}, 1);
    mute = 1'b0;
    repeat (3) @(negedge clk);

    clr(); send(1'b0, 2'd2, 6'd4, 32'h100, 32'h0);
    cyc = 0;
    while (q_data.size() < 1 && cyc < 300) begin @(negedge clk); #1; cyc++; end
    check("mid_first_beat", {31'b0, q_data.size() >= 1}, 1);
    @(negedge clk) reset = 1'b1;
    #1;
    check("mid_rsp_valid", {31'b0, rsp_valid_o}, 0);
    check("mid_rd_req", {31'b0, rd_req_o}, 0);
    check("mid_addr", addr_o, 0);
    check("mid_num", {26'b0, rd_num_dwords_o}, 0);
    check("mid_ready", {31'b0, req_ready_o}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    clr(); send(1'b0, 2'd2, 6'd1, 32'h104, 32'h0); wait_rsp(1);
    if (q_data.size() > 0) begin
      check("post_data", q_data[0], 32'h11110001);
      check("post_err", {31'b0, q_err[0]}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
